lsu_dcache_req_arbiter: RTL and testbench
=========================================

// Module: lsu_dcache_req_arbiter
// PURPOSE
//  Shares the single D$ request port among three LSU requesters: the hella/PTW port,
//  the load queue (LDQ) and the store-drain path for committed STQ entries.
//  - Arbitration: fixed priority, with an anti-starvation boost for stores.
//  - Output: one registered stage; handshake is valid/ready on the D$ side.
//  - Flow control: an in-flight credit counter limits outstanding D$ requests.
//  - Flush: kills speculative load requests that have not yet been sent.
// PARAMETERS
//  MAX_INFLIGHT  4   max D$ requests outstanding (issued, response not yet seen)
//  STARVE_LIMIT  8   cycles a valid store may lose arbitration before it gets priority
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  hl_req_valid   in   1   hella/PTW load request
//  hl_req_ready   out  1   hella request accepted this cycle
//  hl_req_addr    in   64  hella address
//  ld_req_valid   in   1   LDQ load request
//  ld_req_ready   out  1   load accepted this cycle
//  ld_req_addr    in   64  load address
//  ld_req_idx     in   3   LDQ index
//  ld_req_size    in   2   log2 access bytes
//  st_req_valid   in   1   committed store drain request
//  st_req_ready   out  1   store accepted this cycle
//  st_req_addr    in   64  store address
//  st_req_data    in   64  store data
//  st_req_idx     in   3   STQ index
//  st_req_size    in   2   log2 access bytes
//  flush          in   1   pipeline flush; kill loads not yet sent
//  dc_req_valid   out  1   request to D$
//  dc_req_ready   in   1   D$ accepts request
//  dc_req_addr    out  64  D$ address
//  dc_req_data    out  64  D$ store data (0 for loads)
//  dc_req_store   out  1   1 = store, 0 = load
//  dc_req_src     out  2   source: 0 = load, 1 = store, 2 = hella
//  dc_req_idx     out  3   LDQ/STQ index (0 for hella)
//  dc_req_size    out  2   access size (hella = 3)
//  dc_resp_valid  in   1   D$ response or nack; frees one credit
//  busy           out  1   output register valid, or inflight != 0
// BEHAVIOUR
//  - Reset: every output register is cleared to 0, inflight = 0 and starve_cnt = 0.
//  - Output register states:
//    - EMPTY: dc_req_valid = 0.
//    - HOLD: dc_req_valid = 1; contents stay stable until dc_req_ready.
//  - can_load = (!dc_req_valid || dc_req_ready) && (inflight + dc_req_valid < MAX_INFLIGHT).
//  - Priority order is hella > load > store, and a requester is granted only when it is valid.
//  - Boost: when starve_cnt == STARVE_LIMIT, the order becomes store > hella > load.
//  - Loads are never granted while flush = 1.
//  - x_req_ready = grant_x, combinational. Exactly one ready may be high per cycle.
//  - A requester handshake in cycle N gives dc_req_valid = 1 in cycle N+1 (latency 1).
//    Back-to-back issue is supported when dc_req_ready = 1.
//  - Flush while HOLD holds a load and dc_req_ready = 0: the register goes to EMPTY next
//    cycle. The killed load frees no credit.
//  - HOLD with a store or hella request is never killed by flush.
//  - If dc_req_ready = 1 in the same cycle as flush, the load is sent and counts as in flight.
//  - inflight_next = inflight + (dc_req_valid & dc_req_ready) - dc_resp_valid.
//    - A simultaneous issue and response leaves it unchanged.
//    - dc_resp_valid with inflight == 0 is illegal (assertion).
//  - starve_cnt:
//    - Increments while st_req_valid is high and the store is not granted, saturating at
//      STARVE_LIMIT.
//    - Clears on a store grant or when st_req_valid = 0.
//  - Reset during operation drops the held request and the credits, with no handshakes that cycle.
// TESTING
//  - Load at addr 0x80 idx 2, dc_req_ready = 1:
//    -> next cycle dc_req_valid = 1, src = 0, addr = 0x80, idx = 2.
//  - Hella, load and store all valid together:
//    -> hl_req_ready = 1; the load issues next; the store issues last.
//  - Load held continuously valid, store valid for 8 cycles:
//    -> 9th cycle st_req_ready = 1; starve_cnt = 0 afterwards.
//  - 4 issues with no response:
//    -> all req_ready = 0.
//  - Then one dc_resp_valid:
//    -> exactly one more grant.
//  - Load held with dc_req_ready = 0, then flush:
//    -> next cycle dc_req_valid = 0 and inflight unchanged.
//  - Store held, then flush:
//    -> the store stays until dc_req_ready.
//  - Issue and dc_resp_valid in the same cycle with inflight = 2:
//    -> inflight stays 2.

Source files
------------

// File: rtl/lsu_dcache_req_arbiter_if.sv
// lsu_dcache_req_arbiter_if
//   Bundles the three LSU requester ports, the D$ request/response handshake,
//   the flush input and the busy status of lsu_dcache_req_arbiter.
//   modport slave  : the arbiter's view (takes requests, drives the D$ port)
//   modport master : the environment's view (LSU requesters and the D$)
//   Signals:
//     hl_req_*      hella/PTW load request (valid/ready, addr)
//     ld_req_*      LDQ load request (valid/ready, addr, idx, size)
//     st_req_*      committed store drain (valid/ready, addr, data, idx, size)
//     flush         pipeline flush, kills loads not yet sent
//     dc_req_*      request to D$ (valid/ready, addr, data, store, src, idx, size)
//     dc_resp_valid D$ response or nack, returns one credit
//     busy          output register valid or requests outstanding
interface lsu_dcache_req_arbiter_if;
  logic        hl_req_valid;
  logic        hl_req_ready;
  logic [63:0] hl_req_addr;

  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [63:0] ld_req_addr;
  logic [2:0]  ld_req_idx;
  logic [1:0]  ld_req_size;

  logic        st_req_valid;
  logic        st_req_ready;
  logic [63:0] st_req_addr;
  logic [63:0] st_req_data;
  logic [2:0]  st_req_idx;
  logic [1:0]  st_req_size;

  logic        flush;

  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [63:0] dc_req_addr;
  logic [63:0] dc_req_data;
  logic        dc_req_store;
  logic [1:0]  dc_req_src;
  logic [2:0]  dc_req_idx;
  logic [1:0]  dc_req_size;
  logic        dc_resp_valid;

  logic        busy;

  modport slave (
    input  hl_req_valid, hl_req_addr,
    input  ld_req_valid, ld_req_addr, ld_req_idx, ld_req_size,
    input  st_req_valid, st_req_addr, st_req_data, st_req_idx, st_req_size,
    input  flush, dc_req_ready, dc_resp_valid,
    output hl_req_ready, ld_req_ready, st_req_ready,
    output dc_req_valid, dc_req_addr, dc_req_data, dc_req_store,
    output dc_req_src, dc_req_idx, dc_req_size, busy
  );

  modport master (
    output hl_req_valid, hl_req_addr,
    output ld_req_valid, ld_req_addr, ld_req_idx, ld_req_size,
    output st_req_valid, st_req_addr, st_req_data, st_req_idx, st_req_size,
    output flush, dc_req_ready, dc_resp_valid,
    input  hl_req_ready, ld_req_ready, st_req_ready,
    input  dc_req_valid, dc_req_addr, dc_req_data, dc_req_store,
    input  dc_req_src, dc_req_idx, dc_req_size, busy
  );
endinterface

// File: rtl/lsu_dcache_req_arbiter.sv
// lsu_dcache_req_arbiter
//   Shares the single D$ request port among the hella/PTW port, the load queue
//   and the store-drain path. Fixed priority hella > load > store; a store that
//   has lost STARVE_LIMIT cycles in a row is promoted to the top. The winner is
//   captured in a one-entry output register (EMPTY/HOLD) presented to the D$
//   with valid/ready. An in-flight credit counter caps outstanding D$ requests
//   at MAX_INFLIGHT; a flush kills a held load that has not been sent.
//   Ports:
//     clk  clock
//     rst  synchronous reset, active-high
//     bus  lsu_dcache_req_arbiter_if.slave (requesters, D$ port, flush, busy)
module lsu_dcache_req_arbiter #(
  parameter int MAX_INFLIGHT = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                      clk,
  input logic                      rst,
  lsu_dcache_req_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW:0]   MAX_C    = (CW + 1)'(MAX_INFLIGHT);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

  localparam logic [1:0] SRC_LD = 2'd0;
  localparam logic [1:0] SRC_ST = 2'd1;
  localparam logic [1:0] SRC_HL = 2'd2;

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_reg;
  logic [63:0]   addr_reg;
  logic [63:0]   data_reg;
  logic          store_reg;
  logic [1:0]    src_reg;
  logic [2:0]    idx_reg;
  logic [1:0]    size_reg;
  logic [CW-1:0] inflight_reg;
  logic [CW-1:0] inflight_next;
  logic [SW-1:0] starve_cnt_reg;
  logic [SW-1:0] starve_cnt_next;

  logic          hold;
  logic          dc_fire;
  logic          kill_load;
  logic          can_load;
  logic          boost;
  logic [CW:0]   committed;
  logic          grant_hl;
  logic          grant_ld;
  logic          grant_st;

  assign hold    = (state_reg == HOLD);
  assign dc_fire = hold & bus.dc_req_ready;

  // A held request counts against the credit limit even before it is sent,
  // so a new grant never overcommits once the held one fires.
  assign committed = {1'b0, inflight_reg} + {{CW{1'b0}}, hold};
  assign can_load  = (!hold || bus.dc_req_ready) && (committed < MAX_C);
  assign boost     = (starve_cnt_reg == STARVE_C);

  // Only an unsent load is killed; if the D$ takes it this cycle it is already
  // out and keeps its credit.
  assign kill_load = hold && !bus.dc_req_ready && bus.flush && (src_reg == SRC_LD);

  always_comb begin
    grant_hl = 1'b0;
    grant_ld = 1'b0;
    grant_st = 1'b0;
    if (can_load && !rst) begin
      if (boost && bus.st_req_valid) begin
        grant_st = 1'b1;
      end else if (bus.hl_req_valid) begin
        grant_hl = 1'b1;
      end else if (bus.ld_req_valid && !bus.flush) begin
        grant_ld = 1'b1;
      end else if (bus.st_req_valid) begin
        grant_st = 1'b1;
      end
    end
  end

  always_comb begin
    inflight_next = inflight_reg + {{(CW-1){1'b0}}, dc_fire}
                                 - {{(CW-1){1'b0}}, bus.dc_resp_valid};
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!bus.st_req_valid || grant_st) begin
      starve_cnt_next = '0;
    end else if (!boost) begin
      starve_cnt_next = starve_cnt_reg + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= EMPTY;
      addr_reg       <= '0;
      data_reg       <= '0;
      store_reg      <= 1'b0;
      src_reg        <= '0;
      idx_reg        <= '0;
      size_reg       <= '0;
      inflight_reg   <= '0;
      starve_cnt_reg <= '0;
    end else begin
      inflight_reg   <= inflight_next;
      starve_cnt_reg <= starve_cnt_next;
      if (grant_hl) begin
        state_reg <= HOLD;
        addr_reg  <= bus.hl_req_addr;
        data_reg  <= '0;
        store_reg <= 1'b0;
        src_reg   <= SRC_HL;
        idx_reg   <= '0;
        size_reg  <= 2'd3;
      end else if (grant_ld) begin
        state_reg <= HOLD;
        addr_reg  <= bus.ld_req_addr;
        data_reg  <= '0;
        store_reg <= 1'b0;
        src_reg   <= SRC_LD;
        idx_reg   <= bus.ld_req_idx;
        size_reg  <= bus.ld_req_size;
      end else if (grant_st) begin
        state_reg <= HOLD;
        addr_reg  <= bus.st_req_addr;
        data_reg  <= bus.st_req_data;
        store_reg <= 1'b1;
        src_reg   <= SRC_ST;
        idx_reg   <= bus.st_req_idx;
        size_reg  <= bus.st_req_size;
      end else if (dc_fire || kill_load) begin
        state_reg <= EMPTY;
      end
    end
  end

  assign bus.hl_req_ready = grant_hl;
  assign bus.ld_req_ready = grant_ld;
  assign bus.st_req_ready = grant_st;
  assign bus.dc_req_valid = hold;
  assign bus.dc_req_addr  = addr_reg;
  assign bus.dc_req_data  = data_reg;
  assign bus.dc_req_store = store_reg;
  assign bus.dc_req_src   = src_reg;
  assign bus.dc_req_idx   = idx_reg;
  assign bus.dc_req_size  = size_reg;
  assign bus.busy         = hold || (inflight_reg != '0);

  // A response always pairs with an earlier issued request.
  resp_needs_credit: assert property (
    @(posedge clk) disable iff (rst) bus.dc_resp_valid |-> (inflight_reg != '0)
  );

endmodule

// File: tb/tb_lsu_dcache_req_arbiter.sv
// tb_lsu_dcache_req_arbiter
//   Directed bench for lsu_dcache_req_arbiter. Expected D$ requests are queued
//   when the stimulus expects a grant; a monitor pops and compares each request
//   the D$ port accepts. Ready/inflight/starvation checks use hand-derived values.
module tb_lsu_dcache_req_arbiter;

  typedef struct packed {
    logic [1:0]  src;
    logic [63:0] addr;
    logic [63:0] data;
    logic        store;
    logic [2:0]  idx;
    logic [1:0]  size;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_dcache_req_arbiter_if bus();

  lsu_dcache_req_arbiter #(
    .MAX_INFLIGHT(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  txn_t exp_q[$];
  txn_t mon_act;
  txn_t mon_exp;
  int   checks = 0;
  int   errors = 0;
  logic resp_man  = 1'b0;
  logic resp_auto = 1'b0;
  logic auto_en   = 1'b0;
  logic fire_seen;

  assign bus.dc_resp_valid = resp_man | resp_auto;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rdy(input string name, input logic [2:0] exp);
    chk(name, {61'd0, bus.hl_req_ready, bus.ld_req_ready, bus.st_req_ready}, {61'd0, exp});
  endtask

  task automatic push_hl(input logic [63:0] addr);
    exp_q.push_back({2'd2, addr, 64'd0, 1'b0, 3'd0, 2'd3});
  endtask

  task automatic push_ld(input logic [63:0] addr, input logic [2:0] idx, input logic [1:0] size);
    exp_q.push_back({2'd0, addr, 64'd0, 1'b0, idx, size});
  endtask

  task automatic push_st(input logic [63:0] addr, input logic [63:0] data,
                         input logic [2:0] idx, input logic [1:0] size);
    exp_q.push_back({2'd1, addr, data, 1'b1, idx, size});
  endtask

  // Inputs change at posedge+1, outputs are sampled on the negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // D$ side monitor: one line per accepted request.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.dc_req_valid === 1'b1 && bus.dc_req_ready === 1'b1) begin
      mon_act = {bus.dc_req_src, bus.dc_req_addr, bus.dc_req_data,
                 bus.dc_req_store, bus.dc_req_idx, bus.dc_req_size};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dc_issue: unexpected src=%0d addr=%0h", mon_act.src, mon_act.addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL dc_issue: got src=%0d addr=%0h data=%0h st=%0b idx=%0d size=%0d expected src=%0d addr=%0h data=%0h st=%0b idx=%0d size=%0d",
                   mon_act.src, mon_act.addr, mon_act.data, mon_act.store, mon_act.idx, mon_act.size,
                   mon_exp.src, mon_exp.addr, mon_exp.data, mon_exp.store, mon_exp.idx, mon_exp.size);
        end else begin
          $display("issue src=%0d addr=%0h data=%0h st=%0b idx=%0d size=%0d",
                   mon_act.src, mon_act.addr, mon_act.data, mon_act.store, mon_act.idx, mon_act.size);
        end
      end
    end
  end

  // Optional D$ model answering each accepted request one cycle later.
  initial forever begin
    @(negedge clk);
    fire_seen = auto_en && !rst && bus.dc_req_valid && bus.dc_req_ready;
    @(posedge clk);
    #1;
    resp_auto = fire_seen;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.hl_req_valid = 1'b0; bus.hl_req_addr = '0;
    bus.ld_req_valid = 1'b0; bus.ld_req_addr = '0; bus.ld_req_idx = '0; bus.ld_req_size = '0;
    bus.st_req_valid = 1'b0; bus.st_req_addr = '0; bus.st_req_data = '0;
    bus.st_req_idx = '0; bus.st_req_size = '0;
    bus.flush = 1'b0;
    bus.dc_req_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    smp();
    chk("rst_dc_valid", {63'd0, bus.dc_req_valid}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_inflight", 64'(dut.inflight_reg), 64'd0);
    chk("rst_starve", 64'(dut.starve_cnt_reg), 64'd0);
    cyc();

    // Single load, latency 1
    bus.dc_req_ready = 1'b1;
    auto_en = 1'b1;
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 64'h80; bus.ld_req_idx = 3'd2; bus.ld_req_size = 2'd3;
    smp();
    chk_rdy("t1_grant", 3'b010);
    push_ld(64'h80, 3'd2, 2'd3);
    cyc();
    bus.ld_req_valid = 1'b0;
    smp();
    chk("t1_dc_valid", {63'd0, bus.dc_req_valid}, 64'd1);
    cyc();
    repeat (3) cyc();

    // Hella > load > store
    bus.hl_req_valid = 1'b1; bus.hl_req_addr = 64'h100;
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 64'h200; bus.ld_req_idx = 3'd5; bus.ld_req_size = 2'd2;
    bus.st_req_valid = 1'b1; bus.st_req_addr = 64'h300; bus.st_req_data = 64'hdead_beef_0123_4567;
    bus.st_req_idx = 3'd1; bus.st_req_size = 2'd3;
    smp(); chk_rdy("t2_hl_first", 3'b100); push_hl(64'h100);
    cyc(); bus.hl_req_valid = 1'b0;
    smp(); chk_rdy("t2_ld_second", 3'b010); push_ld(64'h200, 3'd5, 2'd2);
    cyc(); bus.ld_req_valid = 1'b0;
    smp(); chk_rdy("t2_st_last", 3'b001); push_st(64'h300, 64'hdead_beef_0123_4567, 3'd1, 2'd3);
    cyc(); bus.st_req_valid = 1'b0;
    smp(); chk_rdy("t2_idle", 3'b000);
    repeat (4) cyc();

    // Store starvation boost
    bus.st_req_valid = 1'b1; bus.st_req_addr = 64'h2000; bus.st_req_data = 64'h55;
    bus.st_req_idx = 3'd3; bus.st_req_size = 2'd2;
    bus.ld_req_valid = 1'b1; bus.ld_req_size = 2'd3;
    for (int k = 0; k < 8; k++) begin
      bus.ld_req_addr = 64'h1000 + 64'(8 * k); bus.ld_req_idx = 3'(k);
      smp();
      chk_rdy("t3_load_wins", 3'b010);
      push_ld(64'h1000 + 64'(8 * k), 3'(k), 2'd3);
      cyc();
    end
    bus.ld_req_addr = 64'h1040; bus.ld_req_idx = 3'd0;
    smp();
    chk("t3_starve_sat", 64'(dut.starve_cnt_reg), 64'd8);
    chk_rdy("t3_store_boost", 3'b001);
    push_st(64'h2000, 64'h55, 3'd3, 2'd2);
    cyc();
    bus.st_req_valid = 1'b0;
    smp();
    chk("t3_starve_clr", 64'(dut.starve_cnt_reg), 64'd0);
    chk_rdy("t3_load_resumes", 3'b010);
    push_ld(64'h1040, 3'd0, 2'd3);
    cyc();
    bus.ld_req_valid = 1'b0;
    repeat (4) cyc();
    auto_en = 1'b0;
    repeat (2) cyc();

    // Credit limit
    smp(); chk("t4_inflight_start", 64'(dut.inflight_reg), 64'd0);
    cyc();
    bus.ld_req_valid = 1'b1; bus.ld_req_size = 2'd1;
    for (int k = 0; k < 4; k++) begin
      bus.ld_req_addr = 64'h4000 + 64'(8 * k); bus.ld_req_idx = 3'(k);
      smp();
      chk_rdy("t4_credit_grant", 3'b010);
      push_ld(64'h4000 + 64'(8 * k), 3'(k), 2'd1);
      cyc();
    end
    bus.ld_req_addr = 64'h4100;
    bus.hl_req_valid = 1'b1; bus.hl_req_addr = 64'h5000;
    bus.st_req_valid = 1'b1; bus.st_req_addr = 64'h6000; bus.st_req_data = 64'h7;
    bus.st_req_idx = 3'd4; bus.st_req_size = 2'd0;
    for (int j = 0; j < 3; j++) begin
      smp(); chk_rdy("t4_no_credit", 3'b000); cyc();
    end
    resp_man = 1'b1;
    smp(); chk_rdy("t4_resp_cycle", 3'b000); chk("t4_inflight_max", 64'(dut.inflight_reg), 64'd4);
    cyc();
    resp_man = 1'b0;
    smp(); chk_rdy("t4_one_more", 3'b100); push_hl(64'h5000);
    cyc();
    for (int j = 0; j < 2; j++) begin
      smp(); chk_rdy("t4_full_again", 3'b000); cyc();
    end
    bus.hl_req_valid = 1'b0; bus.ld_req_valid = 1'b0; bus.st_req_valid = 1'b0;
    resp_man = 1'b1;
    repeat (4) cyc();
    resp_man = 1'b0;
    smp(); chk("t4_drained", 64'(dut.inflight_reg), 64'd0);
    cyc();

    // Flush kills an unsent load and blocks new loads
    bus.dc_req_ready = 1'b0;
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 64'h7000; bus.ld_req_idx = 3'd6; bus.ld_req_size = 2'd2;
    smp(); chk_rdy("t5_grant", 3'b010);
    cyc(); bus.ld_req_valid = 1'b0;
    smp(); chk("t5_hold", {63'd0, bus.dc_req_valid}, 64'd1);
    cyc(); bus.flush = 1'b1;
    smp(); chk("t5_hold_flush", {63'd0, bus.dc_req_valid}, 64'd1);
    cyc(); bus.ld_req_valid = 1'b1; bus.ld_req_addr = 64'h7100;
    smp();
    chk("t5_killed", {63'd0, bus.dc_req_valid}, 64'd0);
    chk("t5_inflight", 64'(dut.inflight_reg), 64'd0);
    chk_rdy("t5_flush_blocks_ld", 3'b000);
    cyc(); bus.flush = 1'b0; bus.ld_req_valid = 1'b0;
    smp(); chk("t5_busy", {63'd0, bus.busy}, 64'd0);
    cyc();

    // Held store survives flush
    bus.st_req_valid = 1'b1; bus.st_req_addr = 64'h8000; bus.st_req_data = 64'h1234;
    bus.st_req_idx = 3'd2; bus.st_req_size = 2'd3;
    smp(); chk_rdy("t6_grant", 3'b001); push_st(64'h8000, 64'h1234, 3'd2, 2'd3);
    cyc(); bus.st_req_valid = 1'b0; bus.flush = 1'b1;
    smp(); cyc();
    smp(); chk("t6_hold_flush", {63'd0, bus.dc_req_valid}, 64'd1);
    cyc(); bus.flush = 1'b0;
    smp(); chk("t6_hold_after", {63'd0, bus.dc_req_valid}, 64'd1);
    cyc(); bus.dc_req_ready = 1'b1;
    smp(); cyc();
    bus.dc_req_ready = 1'b0; resp_man = 1'b1;
    smp(); chk("t6_inflight", 64'(dut.inflight_reg), 64'd1);
    cyc(); resp_man = 1'b0;
    smp(); chk("t6_drained", 64'(dut.inflight_reg), 64'd0);
    cyc();

    // Flush with dc_req_ready: the load is sent
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 64'h9000; bus.ld_req_idx = 3'd7; bus.ld_req_size = 2'd0;
    smp(); chk_rdy("t7_grant", 3'b010); push_ld(64'h9000, 3'd7, 2'd0);
    cyc(); bus.ld_req_valid = 1'b0; bus.flush = 1'b1; bus.dc_req_ready = 1'b1;
    smp(); cyc();
    bus.flush = 1'b0; bus.dc_req_ready = 1'b0; resp_man = 1'b1;
    smp();
    chk("t7_inflight", 64'(dut.inflight_reg), 64'd1);
    chk("t7_empty", {63'd0, bus.dc_req_valid}, 64'd0);
    cyc(); resp_man = 1'b0;
    smp(); chk("t7_drained", 64'(dut.inflight_reg), 64'd0);
    cyc();

    // Issue and response in the same cycle with inflight = 2
    bus.dc_req_ready = 1'b1;
    bus.ld_req_valid = 1'b1; bus.ld_req_size = 2'd3;
    for (int k = 0; k < 3; k++) begin
      bus.ld_req_addr = 64'ha000 + 64'(8 * k); bus.ld_req_idx = 3'(k);
      smp(); chk_rdy("t8_grant", 3'b010); push_ld(64'ha000 + 64'(8 * k), 3'(k), 2'd3);
      cyc();
    end
    bus.ld_req_valid = 1'b0; resp_man = 1'b1;
    smp(); chk("t8_inflight_before", 64'(dut.inflight_reg), 64'd2);
    cyc();
    smp(); chk("t8_inflight_same", 64'(dut.inflight_reg), 64'd2);
    cyc();
    cyc(); resp_man = 1'b0;
    smp(); chk("t8_drained", 64'(dut.inflight_reg), 64'd0);
    cyc();

    smp();
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("end_busy", {63'd0, bus.busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
